// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_align
//  Description : Load/store alignment unit. Lane-shifts store data and byte
//                enables, extracts and extends load data, one access in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_align (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [4:0]  rsp_rd,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_we;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic [4:0]  r_rd;

    logic        r_mem_req_valid;
    logic [31:0] r_mem_addr;
    logic        r_mem_we;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_wdata;
    logic        r_rsp_valid;
    logic [4:0]  r_rsp_rd;
    logic [31:0] r_rsp_data;
    logic        r_rsp_err;

    logic        w_accept;
    logic        w_legal;
    logic        w_misalign;
    logic        w_bad;
    logic [3:0]  w_store_be;
    logic [31:0] w_store_data;
    logic [31:0] w_load_shifted;
    logic [31:0] w_load_data;

    assign req_ready = (r_state == S_IDLE);
    assign w_accept  = req_valid && req_ready;

    // Request decode works on the live request so the error path needs no extra cycle.
    always_comb begin
        w_legal      = 1'b0;
        w_misalign   = 1'b0;
        w_store_be   = 4'b1111;
        w_store_data = req_wdata;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = !req_we;
            default:                w_legal = 1'b0;
        endcase
        case (req_funct3[1:0])
            2'b00: begin
                w_store_be   = 4'b0001 << req_addr[1:0];
                w_store_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_misalign   = req_addr[0];
                w_store_be   = 4'b0011 << req_addr[1:0];
                w_store_data = {2{req_wdata[15:0]}};
            end
            default: begin
                w_misalign   = (req_addr[1:0] != 2'b00);
                w_store_be   = 4'b1111;
                w_store_data = req_wdata;
            end
        endcase
    end

    assign w_bad = !w_legal || w_misalign;

    always_comb begin
        w_load_shifted = mem_rdata >> {r_off, 3'b000};
        case (r_funct3[1:0])
            2'b00:   w_load_data = {{24{!r_funct3[2] && w_load_shifted[7]}},  w_load_shifted[7:0]};
            2'b01:   w_load_data = {{16{!r_funct3[2] && w_load_shifted[15]}}, w_load_shifted[15:0]};
            default: w_load_data = w_load_shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept)      w_state_next = w_bad ? S_DONE : S_REQ;
            S_REQ:  if (mem_req_ready) w_state_next = r_we ? S_DONE : S_WAIT;
            S_WAIT: if (mem_rsp_valid) w_state_next = S_DONE;
            S_DONE:                    w_state_next = S_IDLE;
            default:                   w_state_next = S_IDLE;
        endcase
    end

    // Valid flags follow the next state so every output leaves a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we            <= 1'b0;
            r_funct3        <= 3'd0;
            r_off           <= 2'd0;
            r_rd            <= 5'd0;
            r_mem_req_valid <= 1'b0;
            r_mem_addr      <= 32'd0;
            r_mem_we        <= 1'b0;
            r_mem_be        <= 4'd0;
            r_mem_wdata     <= 32'd0;
            r_rsp_valid     <= 1'b0;
            r_rsp_rd        <= 5'd0;
            r_rsp_data      <= 32'd0;
            r_rsp_err       <= 1'b0;
        end else begin
            r_mem_req_valid <= (w_state_next == S_REQ);
            r_rsp_valid     <= (w_state_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we     <= req_we;
                        r_funct3 <= req_funct3;
                        r_off    <= req_addr[1:0];
                        r_rd     <= req_rd;
                        if (w_bad) begin
                            r_rsp_err  <= 1'b1;
                            r_rsp_rd   <= req_we ? 5'd0 : req_rd;
                            r_rsp_data <= 32'd0;
                        end else begin
                            r_mem_addr  <= {req_addr[31:2], 2'b00};
                            r_mem_we    <= req_we;
                            r_mem_be    <= req_we ? w_store_be : 4'd0;
                            r_mem_wdata <= req_we ? w_store_data : 32'd0;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        r_mem_addr  <= 32'd0;
                        r_mem_we    <= 1'b0;
                        r_mem_be    <= 4'd0;
                        r_mem_wdata <= 32'd0;
                    end
                end
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        r_rsp_data <= w_load_data;
                        r_rsp_rd   <= r_rd;
                    end
                end
                S_DONE: begin
                    r_rsp_data <= 32'd0;
                    r_rsp_rd   <= 5'd0;
                    r_rsp_err  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign mem_req_valid = r_mem_req_valid;
    assign mem_addr      = r_mem_addr;
    assign mem_we        = r_mem_we;
    assign mem_be        = r_mem_be;
    assign mem_wdata     = r_mem_wdata;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rd        = r_rsp_rd;
    assign rsp_data      = r_rsp_data;
    assign rsp_err       = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_align
//  Description : Directed self-checking bench for lsu_align with a
//                per-transaction arithmetic model and a per-cycle comparator.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_align;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [4:0]  req_rd = 5'd0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        rsp_valid;
    logic [4:0]  rsp_rd;
    logic [31:0] rsp_data;
    logic        rsp_err;

    lsu_align u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_rd        (req_rd),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_be        (mem_be),
        .mem_wdata     (mem_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata),
        .rsp_valid     (rsp_valid),
        .rsp_rd        (rsp_rd),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model expectations for the transaction currently in flight.
    bit          in_flight = 1'b0;
    bit          exp_bad;
    logic [31:0] exp_mem_addr;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_rsp_data;
    logic [4:0]  exp_rsp_rd;
    logic        exp_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return mem_addr | mem_wdata | rsp_data |
               {19'b0, mem_req_valid, mem_we, mem_be, rsp_valid, rsp_err, rsp_rd};
    endfunction

    task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input logic [4:0] rd);
        int size;
        bit sgn;
        bit legal;
        int off;
        logic [63:0] v;
        size = 4; sgn = 0; legal = 1;
        case (f3)
            3'd0: begin size = 1; sgn = 1; end
            3'd1: begin size = 2; sgn = 1; end
            3'd2: size = 4;
            3'd4: begin size = 1; legal = !we; end
            3'd5: begin size = 2; legal = !we; end
            default: legal = 0;
        endcase
        off = int'(addr % 4);
        exp_bad      = !legal || ((off % size) != 0);
        exp_mem_addr = addr - 32'(off);
        exp_we       = we;
        exp_be       = we ? 4'(((1 << size) - 1) << off) : 4'd0;
        for (int i = 0; i < 4; i++)
            exp_wd[8*i +: 8] = we ? wdata[8*(i % size) +: 8] : 8'd0;
        v = ({32'd0, rdata} >> (8 * off)) & ((64'd1 << (8 * size)) - 64'd1);
        if (sgn && v >= (64'd1 << (8 * size - 1)))
            v = v - (64'd1 << (8 * size));
        exp_rsp_data = (we || exp_bad) ? 32'd0 : v[31:0];
        exp_rsp_rd   = we ? 5'd0 : rd;
        exp_err      = exp_bad;
    endtask

    // Per-cycle comparator against the model.
    always @(negedge clk) begin
        if (mem_req_valid) begin
            chk("mem_req_allowed", {31'b0, in_flight && !exp_bad}, 32'd1);
            chk("mem_addr", mem_addr, exp_mem_addr);
            chk("mem_we", {31'b0, mem_we}, {31'b0, exp_we});
            chk("mem_be", {28'b0, mem_be}, {28'b0, exp_be});
            chk("mem_wdata", mem_wdata, exp_wd);
        end else begin
            chk("mem_idle_zero", mem_addr | mem_wdata | {27'b0, mem_we, mem_be}, 32'd0);
        end
        if (rsp_valid) begin
            chk("rsp_allowed", {31'b0, in_flight}, 32'd1);
            chk("rsp_data", rsp_data, exp_rsp_data);
            chk("rsp_rd", {27'b0, rsp_rd}, {27'b0, exp_rsp_rd});
            chk("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
        end else begin
            chk("rsp_idle_zero", rsp_data | {26'b0, rsp_err, rsp_rd}, 32'd0);
        end
    end

    // lit_kind: 0 none, 1 rsp_data literal, 2 store lanes literal (lit_a=wdata, lit_b=be).
    task automatic do_access(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] rdata,
                             input int rdly, input int rspdly, input int lit_kind,
                             input logic [31:0] lit_a, input logic [31:0] lit_b);
        int cnt, lat, rc, rsp_cnt, exp_lat;
        bit hs, got, seen_req;
        logic [31:0] cap_wd;
        logic [3:0]  cap_be;
        model(we, f3, addr, wdata, rdata, rd);
        cnt = 0;
        while (!req_ready && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        in_flight  = 1'b1;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;
        lat = 0; rc = 0; rsp_cnt = -1; hs = 0; got = 0; seen_req = 0;
        cap_wd = 32'd0; cap_be = 4'd0;
        while (!got && lat < 60) begin
            @(negedge clk);
            lat++;
            req_valid     = 1'b0;
            mem_rsp_valid = 1'b0;
            mem_rdata     = 32'h5A5A_0F0F;
            if (mem_req_ready) begin
                mem_req_ready = 1'b0;
                hs = 1;
                if (!we) rsp_cnt = rspdly;
            end
            chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
            if (rsp_valid) begin
                got = 1;
            end else begin
                if (mem_req_valid && !hs) begin
                    seen_req = 1;
                    cap_wd = mem_wdata;
                    cap_be = mem_be;
                    if (rc == rdly) mem_req_ready = 1'b1;
                    else rc++;
                end
                if (rsp_cnt == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rdata     = rdata;
                    rsp_cnt       = -1;
                end else if (rsp_cnt > 0) begin
                    rsp_cnt--;
                end
            end
        end
        exp_lat = exp_bad ? 1 : (we ? 2 + rdly : 3 + rdly + rspdly);
        chk("rsp_seen", {31'b0, got}, 32'd1);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("mem_access_seen", {31'b0, seen_req}, {31'b0, !exp_bad});
        if (lit_kind == 1) chk("lit_rsp_data", rsp_data, lit_a);
        if (lit_kind == 2) begin
            chk("lit_mem_wdata", cap_wd, lit_a);
            chk("lit_mem_be", {28'b0, cap_be}, lit_b);
        end
        @(negedge clk);
        chk("rsp_one_cycle", {31'b0, rsp_valid}, 32'd0);
        chk("req_ready_back", {31'b0, req_ready}, 32'd1);
        in_flight = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
        chk("reset_outputs", all_outs(), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_access(0, 3'd0, 32'h103, 0, 5'd5,  32'h80AA_BBCC, 0, 0, 1, 32'hFFFF_FF80, 0);
        do_access(0, 3'd5, 32'h202, 0, 5'd6,  32'h9234_5678, 0, 0, 1, 32'h0000_9234, 0);
        do_access(0, 3'd1, 32'h202, 0, 5'd7,  32'h9234_5678, 0, 0, 1, 32'hFFFF_9234, 0);
        do_access(1, 3'd0, 32'h301, 32'h1234_56A5, 5'd8, 0, 0, 0, 2, 32'hA5A5_A5A5, 32'h2);
        do_access(1, 3'd1, 32'h302, 32'h0000_BEEF, 5'd9, 0, 0, 0, 2, 32'hBEEF_BEEF, 32'hC);
        do_access(0, 3'd2, 32'h402, 0, 5'd10, 32'h1111_2222, 0, 0, 1, 32'h0, 0);
        do_access(1, 3'd1, 32'h001, 32'h0000_1234, 5'd11, 0, 0, 0, 1, 32'h0, 0);
        do_access(0, 3'd3, 32'h000, 0, 5'd12, 32'h3333_4444, 0, 0, 1, 32'h0, 0);
        do_access(1, 3'd4, 32'h010, 32'h0000_0077, 5'd13, 0, 0, 0, 1, 32'h0, 0);
        do_access(1, 3'd2, 32'h500, 32'hDEAD_BEEF, 5'd14, 0, 5, 0, 2, 32'hDEAD_BEEF, 32'hF);
        do_access(0, 3'd4, 32'h007, 0, 5'd15, 32'h8100_0000, 2, 3, 1, 32'h0000_0081, 0);
        do_access(0, 3'd2, 32'h800, 0, 5'd16, 32'h1234_5678, 0, 0, 1, 32'h1234_5678, 0);
        do_access(1, 3'd0, 32'h003, 32'h0000_007F, 5'd17, 0, 1, 0, 2, 32'h7F7F_7F7F, 32'h8);

        // Reset in WAIT abandons the load.
        model(0, 3'd2, 32'h680, 0, 32'h55, 5'd3);
        in_flight  = 1'b1;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = 32'h680;
        req_rd     = 5'd3;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_mem_req", {31'b0, mem_req_valid}, 32'd1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst_n = 1'b0;
        in_flight = 1'b0;
        #1;
        chk("abort_outputs_zero", all_outs(), 32'd0);
        chk("abort_req_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h0BAD_F00D;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            chk("abort_no_rsp", {31'b0, rsp_valid}, 32'd0);
            chk("abort_no_mem", {31'b0, mem_req_valid}, 32'd0);
            chk("abort_ready", {31'b0, req_ready}, 32'd1);
        end

        do_access(0, 3'd2, 32'h600, 0, 5'd20, 32'hCAFE_F00D, 0, 0, 1, 32'hCAFE_F00D, 0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
